// File: rtl/addition_stage3_if.sv
// Stage-2 to stage-3 to stage-4 handshake bundle of the FP add/sub pipeline.
// The slave modport is the stage-3 view; the master modport drives it.
interface addition_stage3_if #(
    parameter int MENT_WIDTH = 23,
    parameter int EXPO_WIDTH = 8
);
    logic                  in_valid;
    logic                  in_ready;
    logic [MENT_WIDTH-1:0] larger_mant_in;
    logic [MENT_WIDTH:0]   smaller_mant_in;
    logic [EXPO_WIDTH-1:0] exponent_in;
    logic                  sign_large_in;
    logic                  sign_small_in;
    logic                  out_valid;
    logic                  out_ready;
    logic [MENT_WIDTH+1:0] mant_sum_out;
    logic [EXPO_WIDTH-1:0] exponent_out;
    logic                  sign_out;
    logic                  zero_out;

    modport slave (
        input  in_valid, larger_mant_in, smaller_mant_in, exponent_in,
               sign_large_in, sign_small_in, out_ready,
        output in_ready, out_valid, mant_sum_out, exponent_out, sign_out, zero_out
    );

    modport master (
        output in_valid, larger_mant_in, smaller_mant_in, exponent_in,
               sign_large_in, sign_small_in, out_ready,
        input  in_ready, out_valid, mant_sum_out, exponent_out, sign_out, zero_out
    );
endinterface

// File: rtl/addition_stage3.sv
// FP add/sub stage 3: signed-magnitude significand add/subtract, captured
// into a 2-entry skid buffer so in_ready comes straight from a flop.
module addition_stage3 #(
    parameter int MENT_WIDTH = 23,
    parameter int EXPO_WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    addition_stage3_if.slave   bus
);
    localparam int SUM_W = MENT_WIDTH + 2;

    typedef struct packed {
        logic [SUM_W-1:0]      mag;
        logic [EXPO_WIDTH-1:0] expo;
        logic                  sign;
        logic                  zero;
    } entry_t;

    localparam int ENTRY_W = $bits(entry_t);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_BUSY  = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    // Magnitude subtraction picks the larger significand as minuend; a zero
    // result is always reported as +0.
    function automatic entry_t compute_entry(
        input logic [MENT_WIDTH-1:0] larger_mant,
        input logic [MENT_WIDTH:0]   smaller_mant,
        input logic [EXPO_WIDTH-1:0] expo,
        input logic                  sign_large,
        input logic                  sign_small
    );
        entry_t           res;
        logic [SUM_W-1:0] a_v;
        logic [SUM_W-1:0] b_v;
        logic [SUM_W-1:0] mag_v;
        logic             sign_v;
        a_v = {1'b0, 1'b1, larger_mant};
        b_v = {1'b0, smaller_mant};
        if ((sign_large ^ sign_small) == 1'b0) begin
            mag_v  = a_v + b_v;
            sign_v = sign_large;
        end else if (a_v >= b_v) begin
            mag_v  = a_v - b_v;
            sign_v = sign_large;
        end else begin
            mag_v  = b_v - a_v;
            sign_v = sign_small;
        end
        res.mag  = mag_v;
        res.expo = expo;
        res.zero = (mag_v == {SUM_W{1'b0}});
        res.sign = sign_v & ~res.zero;
        return res;
    endfunction

    state_t state_q, state_d;
    entry_t main_q, main_d;
    entry_t skid_q, skid_d;
    logic   in_ready_q, in_ready_d;
    logic   out_valid_q, out_valid_d;
    entry_t new_entry_s;
    logic   accept_s;
    logic   drain_s;

    // Next-state, buffer steering and registered handshake outputs.
    always_comb begin
        new_entry_s = compute_entry(bus.larger_mant_in, bus.smaller_mant_in,
                                    bus.exponent_in, bus.sign_large_in,
                                    bus.sign_small_in);
        accept_s    = bus.in_valid & in_ready_q;
        drain_s     = out_valid_q & bus.out_ready;
        state_d     = state_q;
        main_d      = main_q;
        skid_d      = skid_q;
        case (state_q)
            ST_EMPTY: begin
                if (accept_s) begin
                    main_d  = new_entry_s;
                    state_d = ST_BUSY;
                end else begin
                    state_d = ST_EMPTY;
                end
            end
            ST_BUSY: begin
                if (accept_s && drain_s) begin
                    main_d = new_entry_s;
                end else if (drain_s) begin
                    state_d = ST_EMPTY;
                end else if (accept_s) begin
                    skid_d  = new_entry_s;
                    state_d = ST_FULL;
                end else begin
                    state_d = ST_BUSY;
                end
            end
            ST_FULL: begin
                if (drain_s) begin
                    main_d  = skid_q;
                    state_d = ST_BUSY;
                end else begin
                    state_d = ST_FULL;
                end
            end
            default: begin
                state_d = ST_EMPTY;
            end
        endcase
        in_ready_d  = (state_d != ST_FULL);
        out_valid_d = (state_d != ST_EMPTY);
    end

    // State, data entries and handshake flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_EMPTY;
            main_q      <= entry_t'({ENTRY_W{1'b0}});
            skid_q      <= entry_t'({ENTRY_W{1'b0}});
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            main_q      <= main_d;
            skid_q      <= skid_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.in_ready     = in_ready_q;
    assign bus.out_valid    = out_valid_q;
    assign bus.mant_sum_out = main_q.mag;
    assign bus.exponent_out = main_q.expo;
    assign bus.sign_out     = main_q.sign;
    assign bus.zero_out     = main_q.zero;
endmodule

// File: tb/tb_addition_stage3.sv
// Self-checking bench for addition_stage3: directed cases, backpressure,
// random streaming and reset in the full state, against a signed-integer model.
module tb_addition_stage3;
    logic clk;
    logic rst_n;
    int   total;
    int   bad;
    int   idx;
    logic acc;

    typedef struct {
        logic [24:0] mag;
        logic [7:0]  e;
        logic        s;
        logic        z;
    } exp_t;

    exp_t        q[$];
    logic [22:0] it_l[3];
    logic [23:0] it_s[3];
    logic [7:0]  it_e[3];
    logic        it_sl[3];
    logic        it_ss[3];

    addition_stage3_if #(.MENT_WIDTH(23), .EXPO_WIDTH(8)) bus ();

    addition_stage3 #(.MENT_WIDTH(23), .EXPO_WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: treat each operand as a signed integer and take |sum|.
    function automatic exp_t model(input logic [22:0] l, input logic [23:0] s,
                                   input logic [7:0] e, input logic sl, input logic ss);
        exp_t   r;
        longint a;
        longint b;
        longint v;
        a = longint'(l) + 64'sd8388608;
        b = longint'(s);
        v = (sl ? -a : a) + (ss ? -b : b);
        r.mag = 25'((v < 0) ? -v : v);
        r.s   = (v < 0);
        r.z   = (v == 0);
        r.e   = e;
        return r;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, expv);
        end
    endtask

    task automatic drive(input logic [22:0] l, input logic [23:0] s, input logic [7:0] e,
                         input logic sl, input logic ss);
        bus.larger_mant_in  = l;
        bus.smaller_mant_in = s;
        bus.exponent_in     = e;
        bus.sign_large_in   = sl;
        bus.sign_small_in   = ss;
    endtask

    task automatic drive_rand();
        logic [22:0] l;
        logic [23:0] s;
        l = 23'($urandom());
        case ($urandom_range(0, 3))
            0:       s = {1'b1, l};
            1:       s = 24'd0;
            default: s = 24'($urandom());
        endcase
        drive(l, s, 8'($urandom()), 1'($urandom()), 1'($urandom()));
    endtask

    // One clock: check presented output against scoreboard, record transfers.
    task automatic cycle();
        logic a;
        logic d;
        if (bus.out_valid) begin
            if (q.size() == 0) begin
                chk("spurious_valid", 64'(bus.out_valid), 64'd0);
            end else begin
                chk("mag",  64'(bus.mant_sum_out), 64'(q[0].mag));
                chk("expo", 64'(bus.exponent_out), 64'(q[0].e));
                chk("sign", 64'(bus.sign_out),     64'(q[0].s));
                chk("zero", 64'(bus.zero_out),     64'(q[0].z));
            end
        end
        a = bus.in_valid && bus.in_ready;
        d = bus.out_valid && bus.out_ready;
        if (d && q.size() > 0) void'(q.pop_front());
        if (a) q.push_back(model(bus.larger_mant_in, bus.smaller_mant_in, bus.exponent_in,
                                 bus.sign_large_in, bus.sign_small_in));
        @(posedge clk);
        #1;
    endtask

    task automatic directed(input string tag, input logic [22:0] l, input logic [23:0] s,
                            input logic sl, input logic ss, input logic [24:0] emag,
                            input logic esign, input logic ezero);
        drive(l, s, 8'h7F, sl, ss);
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        chk({tag, "_in_ready"}, 64'(bus.in_ready), 64'd1);
        cycle();
        bus.in_valid = 1'b0;
        chk({tag, "_valid"}, 64'(bus.out_valid),    64'd1);
        chk({tag, "_mag"},   64'(bus.mant_sum_out), 64'(emag));
        chk({tag, "_sign"},  64'(bus.sign_out),     64'(esign));
        chk({tag, "_zero"},  64'(bus.zero_out),     64'(ezero));
        chk({tag, "_expo"},  64'(bus.exponent_out), 64'h7F);
        cycle();
        chk({tag, "_empty"}, 64'(bus.out_valid), 64'd0);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        drive(23'd0, 24'd0, 8'd0, 1'b0, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rst_valid", 64'(bus.out_valid),    64'd0);
        chk("rst_mag",   64'(bus.mant_sum_out), 64'd0);
        chk("rst_expo",  64'(bus.exponent_out), 64'd0);
        chk("rst_sign",  64'(bus.sign_out),     64'd0);
        chk("rst_zero",  64'(bus.zero_out),     64'd0);
        rst_n = 1'b1;
        chk("rst_in_ready", 64'(bus.in_ready), 64'd1);

        directed("one_plus_one", 23'd0,        24'h800000, 1'b0, 1'b0, 25'h1000000, 1'b0, 1'b0);
        directed("cancel",       23'h400000,   24'hC00000, 1'b0, 1'b1, 25'h0,       1'b0, 1'b1);
        directed("swap_sub",     23'd0,        24'hC00000, 1'b0, 1'b1, 25'h400000,  1'b1, 1'b0);
        directed("zero_small",   23'h123456,   24'h000000, 1'b1, 1'b0, 25'h923456,  1'b1, 1'b0);

        // Backpressure: two accepted, third held until release.
        for (int i = 0; i < 3; i++) begin
            it_l[i]  = 23'($urandom());
            it_s[i]  = 24'($urandom());
            it_e[i]  = 8'($urandom());
            it_sl[i] = 1'($urandom());
            it_ss[i] = 1'($urandom());
        end
        bus.out_ready = 1'b0;
        idx = 0;
        for (int k = 0; k < 4; k++) begin
            drive(it_l[idx], it_s[idx], it_e[idx], it_sl[idx], it_ss[idx]);
            bus.in_valid = 1'b1;
            chk($sformatf("bp_in_ready%0d", k), 64'(bus.in_ready), (k < 2) ? 64'd1 : 64'd0);
            acc = bus.in_ready;
            cycle();
            if (acc) idx++;
        end
        chk("bp_held", 64'(idx), 64'd2);
        bus.out_ready = 1'b1;
        for (int k = 0; k < 20; k++) begin
            if (idx == 3 && q.size() == 0 && !bus.out_valid) break;
            if (idx < 3) begin
                drive(it_l[idx], it_s[idx], it_e[idx], it_sl[idx], it_ss[idx]);
                bus.in_valid = 1'b1;
            end else begin
                bus.in_valid = 1'b0;
            end
            acc = bus.in_valid && bus.in_ready;
            cycle();
            if (acc) idx++;
        end
        chk("bp_all_accepted", 64'(idx),        64'd3);
        chk("bp_drained",      64'(q.size()),   64'd0);
        chk("bp_idle",         64'(bus.out_valid), 64'd0);

        // Streaming: one result per cycle, in_ready never drops.
        bus.out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            drive_rand();
            bus.in_valid = 1'b1;
            chk($sformatf("st_in_ready%0d", k), 64'(bus.in_ready), 64'd1);
            if (k > 0) chk($sformatf("st_valid%0d", k), 64'(bus.out_valid), 64'd1);
            cycle();
        end
        bus.in_valid = 1'b0;
        chk("st_last_valid", 64'(bus.out_valid), 64'd1);
        cycle();
        chk("st_idle",  64'(bus.out_valid), 64'd0);
        chk("st_empty", 64'(q.size()),      64'd0);

        // Reset while FULL.
        bus.out_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            drive_rand();
            bus.in_valid = 1'b1;
            cycle();
        end
        bus.in_valid = 1'b0;
        chk("full_in_ready", 64'(bus.in_ready), 64'd0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mrst_valid", 64'(bus.out_valid),    64'd0);
        chk("mrst_mag",   64'(bus.mant_sum_out), 64'd0);
        chk("mrst_expo",  64'(bus.exponent_out), 64'd0);
        chk("mrst_sign",  64'(bus.sign_out),     64'd0);
        chk("mrst_zero",  64'(bus.zero_out),     64'd0);
        q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("mrst_in_ready", 64'(bus.in_ready), 64'd1);
        drive_rand();
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        cycle();
        bus.in_valid = 1'b0;
        chk("mrst_result_valid", 64'(bus.out_valid), 64'd1);
        cycle();
        chk("mrst_no_skid", 64'(bus.out_valid), 64'd0);
        chk("mrst_empty",   64'(q.size()),      64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
